// File: rtl/stack_overflow_monitor.sv
// rtl/stack_overflow_monitor.sv - stack-pointer overflow monitor with sticky flag, irq pulse and low-water mark
module stack_overflow_monitor #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_reportSP,
  input  logic [1:0]       i_cfgAddr,
  input  logic [WIDTH-1:0] i_cfgWData,
  input  logic             i_cfgWEn,
  output logic [WIDTH-1:0] o_cfgRData,
  output logic             o_ovflFlag,
  output logic             o_ovflIrq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LIMIT  = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_HWM    = 2'd3;

  state_t           state;
  logic             ctrl_en;
  logic             ctrl_irq_en;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] hwm;
  logic             flag;
  logic             irq;

  logic wr_ctrl;
  logic wr_limit;
  logic wr_status;
  logic wr_hwm;
  logic status_clr;
  logic disable_wr;
  logic enable_wr;
  logic cond;

  assign wr_ctrl    = i_cfgWEn && (i_cfgAddr == ADDR_CTRL);
  assign wr_limit   = i_cfgWEn && (i_cfgAddr == ADDR_LIMIT);
  assign wr_status  = i_cfgWEn && (i_cfgAddr == ADDR_STATUS);
  assign wr_hwm     = i_cfgWEn && (i_cfgAddr == ADDR_HWM);
  assign status_clr = wr_status && i_cfgWData[0];
  assign disable_wr = wr_ctrl && !i_cfgWData[0];
  assign enable_wr  = wr_ctrl && i_cfgWData[0];

  // Stack grows downward: overflow when the sampled SP is below the limit (LIMIT=0 never trips)
  assign cond = (sp_q < limit);

  // Software-visible configuration registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      limit       <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= i_cfgWData[0];
        ctrl_irq_en <= i_cfgWData[1];
      end
      if (wr_limit) begin
        limit <= i_cfgWData;
      end
    end
  end

  // Register the reported SP so the compare sees a stable value one cycle later
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sp_q <= '0;
    end else begin
      sp_q <= i_reportSP;
    end
  end

  // Monitor FSM with registered flag and single-cycle irq
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      flag  <= 1'b0;
      irq   <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (disable_wr) begin
        // Disable wins over any trip this cycle; the flag is kept unless cleared
        state <= IDLE;
        if (status_clr) begin
          flag <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (status_clr) begin
              flag <= 1'b0;
            end
            if (enable_wr) begin
              state <= ARMED;
            end
          end
          ARMED: begin
            // A trip takes priority over a same-cycle clear so the event is not lost
            if (cond) begin
              state <= TRIPPED;
              flag  <= 1'b1;
              irq   <= ctrl_irq_en;
            end else if (status_clr) begin
              flag <= 1'b0;
            end
          end
          TRIPPED: begin
            // The RECOVER/ARMED choice uses the limit in force this cycle
            if (status_clr) begin
              flag  <= 1'b0;
              state <= cond ? RECOVER : ARMED;
            end
          end
          RECOVER: begin
            if (status_clr) begin
              flag <= 1'b0;
            end
            if (!cond) begin
              state <= ARMED;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Low-water mark of SP while monitoring; a write reloads all ones and overrides the update
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hwm <= {WIDTH{1'b1}};
    end else if (wr_hwm) begin
      hwm <= {WIDTH{1'b1}};
    end else if (ctrl_en && (state != IDLE) && (sp_q < hwm)) begin
      hwm <= sp_q;
    end
  end

  // Combinational register read mux
  always_comb begin
    o_cfgRData = '0;
    case (i_cfgAddr)
      ADDR_CTRL:   o_cfgRData = {{(WIDTH-2){1'b0}}, ctrl_irq_en, ctrl_en};
      ADDR_LIMIT:  o_cfgRData = limit;
      ADDR_STATUS: o_cfgRData = {{(WIDTH-2){1'b0}}, (state == ARMED), flag};
      ADDR_HWM:    o_cfgRData = hwm;
      default:     o_cfgRData = '0;
    endcase
  end

  assign o_ovflFlag = flag;
  assign o_ovflIrq  = irq;

endmodule

// File: tb/tb_stack_overflow_monitor.sv
// tb/tb_stack_overflow_monitor.sv - directed self-checking bench for stack_overflow_monitor
module tb_stack_overflow_monitor;

  logic        clk;
  logic        rstn;
  logic [15:0] report_sp;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_wen;
  logic [15:0] cfg_rdata;
  logic        ovfl_flag;
  logic        ovfl_irq;

  int n_assert = 0;
  int n_fail   = 0;
  int irq_cnt  = 0;
  int irq_base = 0;

  stack_overflow_monitor #(.WIDTH(16)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_reportSP (report_sp),
    .i_cfgAddr  (cfg_addr),
    .i_cfgWData (cfg_wdata),
    .i_cfgWEn   (cfg_wen),
    .o_cfgRData (cfg_rdata),
    .o_ovflFlag (ovfl_flag),
    .o_ovflIrq  (ovfl_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count irq pulses away from the active edge
  always @(negedge clk) begin
    if (ovfl_irq === 1'b1) irq_cnt = irq_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wen   = 1'b1;
    tick();
    cfg_wen   = 1'b0;
    cfg_wdata = 16'h0000;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  initial begin
    rstn      = 1'b0;
    report_sp = 16'h0000;
    cfg_addr  = 2'd0;
    cfg_wdata = 16'h0000;
    cfg_wen   = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Reset state
    chk("reset_flag", {15'd0, ovfl_flag}, 16'h0000);
    chk("reset_irq", {15'd0, ovfl_irq}, 16'h0000);
    rd(2'd0, 16'h0000, "reset_ctrl");
    rd(2'd1, 16'h0000, "reset_limit");
    rd(2'd3, 16'hFFFF, "reset_hwm");
    tick();
    rd(2'd2, 16'h0000, "reset_status");

    // Basic trip setup
    report_sp = 16'h0200;
    wr(2'd1, 16'h0100);
    wr(2'd0, 16'h0003);
    rd(2'd0, 16'h0003, "ctrl_readback");
    rd(2'd2, 16'h0002, "armed_status");
    irq_base = irq_cnt;

    // Boundary: SP equal to LIMIT does not trip
    report_sp = 16'h0100;
    tick();
    tick();
    tick();
    chk("boundary_flag", {15'd0, ovfl_flag}, 16'h0000);
    rd(2'd2, 16'h0002, "boundary_status");

    // Trip: SP=00FF presented in cycle k
    report_sp = 16'h00FF;
    tick();
    chk("trip_k1_flag", {15'd0, ovfl_flag}, 16'h0000);
    chk("trip_k1_irq", {15'd0, ovfl_irq}, 16'h0000);
    report_sp = 16'h00F0;
    tick();
    chk("trip_k2_flag", {15'd0, ovfl_flag}, 16'h0001);
    chk("trip_k2_irq", {15'd0, ovfl_irq}, 16'h0001);
    tick();
    chk("trip_k3_irq", {15'd0, ovfl_irq}, 16'h0000);
    rd(2'd2, 16'h0001, "trip_status");

    // Clear while SP still below limit -> RECOVER, flag clear, no new irq
    wr(2'd2, 16'h0001);
    chk("clear_flag", {15'd0, ovfl_flag}, 16'h0000);
    rd(2'd2, 16'h0000, "recover_status");
    tick();
    tick();
    chk("recover_no_irq", 16'(irq_cnt - irq_base), 16'd1);

    // Leave RECOVER, then trip again
    report_sp = 16'h0180;
    tick();
    tick();
    rd(2'd2, 16'h0002, "rearmed_status");
    report_sp = 16'h0080;
    tick();
    tick();
    chk("trip2_flag", {15'd0, ovfl_flag}, 16'h0001);
    chk("trip2_irq", {15'd0, ovfl_irq}, 16'h0001);
    tick();
    chk("irq_total_two", 16'(irq_cnt - irq_base), 16'd2);

    // Clear with SP above limit -> ARMED
    report_sp = 16'h0200;
    tick();
    tick();
    wr(2'd2, 16'h0001);
    rd(2'd2, 16'h0002, "clear_to_armed");

    // irqEn=0: flag sets, no irq
    wr(2'd0, 16'h0001);
    irq_base = irq_cnt;
    report_sp = 16'h0050;
    tick();
    tick();
    chk("masked_flag", {15'd0, ovfl_flag}, 16'h0001);
    chk("masked_irq", {15'd0, ovfl_irq}, 16'h0000);
    tick();
    chk("masked_irq_cnt", 16'(irq_cnt - irq_base), 16'd0);
    report_sp = 16'h0200;
    tick();
    tick();
    wr(2'd2, 16'h0001);
    chk("masked_clear", {15'd0, ovfl_flag}, 16'h0000);

    // Disable: no trip with SP=0, armed bit reads 0
    wr(2'd0, 16'h0000);
    rd(2'd2, 16'h0000, "idle_status");
    report_sp = 16'h0000;
    tick();
    tick();
    tick();
    chk("disabled_flag", {15'd0, ovfl_flag}, 16'h0000);
    rd(2'd2, 16'h0000, "disabled_status");

    // HWM tracking
    wr(2'd3, 16'h0000);
    rd(2'd3, 16'hFFFF, "hwm_reload_idle");
    report_sp = 16'h0300;
    wr(2'd0, 16'h0001);
    report_sp = 16'h0250;
    tick();
    report_sp = 16'h0280;
    tick();
    tick();
    rd(2'd3, 16'h0250, "hwm_min");
    wr(2'd3, 16'h1234);
    rd(2'd3, 16'hFFFF, "hwm_write_reload");

    // Same-cycle trip and STATUS clear in ARMED: trip wins
    report_sp = 16'h0080;
    tick();
    wr(2'd2, 16'h0001);
    chk("trip_vs_clear_flag", {15'd0, ovfl_flag}, 16'h0001);

    // Asynchronous reset mid-trip
    rstn = 1'b0;
    #1;
    chk("async_reset_flag", {15'd0, ovfl_flag}, 16'h0000);
    chk("async_reset_irq", {15'd0, ovfl_irq}, 16'h0000);
    tick();
    rstn = 1'b1;
    irq_base = irq_cnt;
    tick();
    rd(2'd0, 16'h0000, "post_reset_ctrl");
    rd(2'd1, 16'h0000, "post_reset_limit");
    rd(2'd3, 16'hFFFF, "post_reset_hwm");
    tick();
    tick();
    chk("post_reset_flag", {15'd0, ovfl_flag}, 16'h0000);
    chk("post_reset_irq_cnt", 16'(irq_cnt - irq_base), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
